// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: control for a 5-stage RV32I pipeline.
// - Decodes the ID-stage opcode into a control word.
// - Carries that word through the ID/EX, EX/MEM and MEM/WB control registers.
// - Owns load-use stall insertion, redirect flush and operand-forwarding selects.
// Optional feature macro: CTRL_MULDIV_EN. When defined, R-type instructions
// with funct7[0]=1 decode as M-extension ops. Divide/remainder ops then occupy
// EX for DIV_LAT cycles.
module ctrl_pipe_unit #(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_0,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush,
  output logic              ex_isBranch,
  output logic              ex_Jump,
  output logic              ex_ALUSrc,
  output logic [1:0]        ex_ALUOp,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic              wb_RegWrite,
  output logic              wb_MemtoReg,
  output logic [1:0]        wb_WBSrc,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_illegal
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Control slices, grouped by the stage that consumes them.
  typedef struct packed {
    logic       isbranch;
    logic       jump;
    logic       alusrc;
    logic [1:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] wbsrc;
  } wb_ctrl_t;

  // Each stage register keeps only what its own and later stages still need.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    ex_ctrl_t          ex;
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
    logic              illegal;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    wb_ctrl_t          wb;
  } memwb_t;

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;
  logic      dec_illegal;
  logic      dec_uses_rs2;
`ifdef CTRL_MULDIV_EN
  logic      dec_div;
`endif

  idex_t  id_entry;
  idex_t  idex;
  exmem_t exmem;
  memwb_t memwb;

  logic load_use;
  logic div_busy;
  logic idex_load;

  // funct fields only matter to the M-extension decode; fold them here so an
  // unused bit is never left dangling in either build.
  logic unused_fields;
  assign unused_fields = ^{id_funct3, id_funct7_0};

  // Opcode decode of the instruction sitting in IF/ID.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    dec_ex       = '0;
    dec_mem      = '0;
    dec_wb       = '0;
    dec_illegal  = 1'b0;
    dec_uses_rs2 = 1'b0;
`ifdef CTRL_MULDIV_EN
    dec_div      = 1'b0;
`endif
    case (id_opcode)
      OP_R: begin
        dec_ex.aluop    = 2'b10;
        dec_wb.regwrite = 1'b1;
        dec_uses_rs2    = 1'b1;
`ifdef CTRL_MULDIV_EN
        if (id_funct7_0) begin
          dec_ex.aluop = 2'b11;
          dec_div      = id_funct3[2];
        end
`endif
      end
      OP_I: begin
        dec_ex.aluop    = 2'b10;
        dec_ex.alusrc   = 1'b1;
        dec_wb.regwrite = 1'b1;
      end
      OP_LOAD: begin
        dec_mem.memread = 1'b1;
        dec_wb.memtoreg = 1'b1;
        dec_ex.alusrc   = 1'b1;
        dec_wb.regwrite = 1'b1;
      end
      OP_STORE: begin
        dec_ex.alusrc    = 1'b1;
        dec_mem.memwrite = 1'b1;
        dec_uses_rs2     = 1'b1;
      end
      OP_BRANCH: begin
        dec_ex.isbranch = 1'b1;
        dec_ex.aluop    = 2'b01;
        dec_uses_rs2    = 1'b1;
      end
      OP_JAL: begin
        dec_wb.regwrite = 1'b1;
        dec_ex.jump     = 1'b1;
        dec_wb.wbsrc    = 2'b11;
      end
      OP_JALR: begin
        dec_ex.alusrc   = 1'b1;
        dec_wb.regwrite = 1'b1;
        dec_ex.jump     = 1'b1;
        dec_wb.wbsrc    = 2'b11;
      end
      OP_AUIPC: begin
        dec_wb.regwrite = 1'b1;
        dec_wb.wbsrc    = 2'b10;
      end
      OP_LUI: begin
        dec_wb.regwrite = 1'b1;
        dec_wb.wbsrc    = 2'b01;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Candidate ID/EX contents; an invalid IF/ID slot becomes an all-zero bubble.
  always_comb begin
    id_entry = '0;
    if (id_valid) begin
      id_entry.valid   = 1'b1;
      id_entry.rd      = id_rd;
      id_entry.rs1     = id_rs1;
      id_entry.rs2     = id_rs2;
      id_entry.ex      = dec_ex;
      id_entry.mem     = dec_mem;
      id_entry.wb      = dec_wb;
      id_entry.illegal = dec_illegal;
    end
  end

  // A load in EX whose result the ID instruction needs next cycle.
  // rs2 only counts for formats that actually read it.
  assign load_use = idex.valid && idex.mem.memread && (idex.rd != '0) &&
                    ((idex.rd == id_rs1) || (dec_uses_rs2 && (idex.rd == id_rs2)));

`ifdef CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(DIV_LAT);

  logic [CNT_W-1:0] div_cnt;

  assign div_busy = (div_cnt != '0);

  // Divide occupancy counter: loads on EX entry, counts down while EX holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_busy) begin
      div_cnt <= div_cnt - CNT_W'(1);
    end else if (idex_load && id_valid && dec_div) begin
      div_cnt <= CNT_W'(DIV_LAT - 1);
    end
  end

  // The front end cannot redirect while EX is still working on a divide.
  a_no_redirect_in_div: assert property (@(posedge clk) disable iff (!rst_n)
                                         !(div_busy && ex_redirect));
`else
  localparam int unused_div_lat = DIV_LAT;

  assign div_busy = 1'b0;
`endif

  // Redirect beats everything; a busy divide holds EX; a load-use hazard bubbles.
  assign idex_load = !ex_redirect && !div_busy && !load_use;

  // ID/EX control register.
  always_ff @(posedge clk) begin
    // NOTE: all stage registers are reset, because a stale valid bit or control
    // bit after reset would issue phantom register writes or memory accesses.
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignment, so every
      // stage samples the previous stage's value from before this edge.
      idex <= '0;
    end else if (ex_redirect) begin
      idex <= '0;
    end else if (div_busy) begin
      idex <= idex;
    end else if (load_use) begin
      idex <= '0;
    end else begin
      idex <= id_entry;
    end
  end

  // EX/MEM control register; it takes bubbles while a divide holds EX.
  always_ff @(posedge clk) begin
    if (!rst_n || div_busy) begin
      exmem <= '0;
    end else begin
      exmem.valid <= idex.valid;
      exmem.rd    <= idex.rd;
      exmem.mem   <= idex.mem;
      exmem.wb    <= idex.wb;
    end
  end

  // MEM/WB control register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb <= '0;
    end else begin
      memwb.valid <= exmem.valid;
      memwb.rd    <= exmem.rd;
      memwb.wb    <= exmem.wb;
    end
  end

  // Forwarding: the younger producer (EX/MEM) wins; x0 never forwards.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (exmem.valid && exmem.wb.regwrite && (exmem.rd != '0) && (exmem.rd == idex.rs1)) begin
      fwd_a = FWD_EXMEM;
    end else if (memwb.valid && memwb.wb.regwrite && (memwb.rd != '0) &&
                 (memwb.rd == idex.rs1)) begin
      fwd_a = FWD_MEMWB;
    end
    if (exmem.valid && exmem.wb.regwrite && (exmem.rd != '0) && (exmem.rd == idex.rs2)) begin
      fwd_b = FWD_EXMEM;
    end else if (memwb.valid && memwb.wb.regwrite && (memwb.rd != '0) &&
                 (memwb.rd == idex.rs2)) begin
      fwd_b = FWD_MEMWB;
    end
  end

  assign flush = ex_redirect;
  assign stall = !ex_redirect && (load_use || div_busy);

  // Per-stage control outputs, forced to 0 for an invalid stage.
  assign ex_isBranch  = idex.valid && idex.ex.isbranch;
  assign ex_Jump      = idex.valid && idex.ex.jump;
  assign ex_ALUSrc    = idex.valid && idex.ex.alusrc;
  assign ex_ALUOp     = idex.valid ? idex.ex.aluop : 2'b00;
  assign ex_illegal   = idex.valid && idex.illegal;
  assign mem_MemRead  = exmem.valid && exmem.mem.memread;
  assign mem_MemWrite = exmem.valid && exmem.mem.memwrite;
  assign wb_RegWrite  = memwb.valid && memwb.wb.regwrite;
  assign wb_MemtoReg  = memwb.valid && memwb.wb.memtoreg;
  assign wb_WBSrc     = memwb.valid ? memwb.wb.wbsrc : 2'b00;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit.
// A scoreboard queues the expected MEM and WB control for every accepted
// instruction and compares it in the cycle it is due. Cycles with nothing due
// must show all-zero control. EX, stall, flush and forwarding are checked
// inline by each scenario task.
module tb_ctrl_pipe_unit;

  localparam int DIV_LAT = 4;
`ifdef CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [4:0] OP_TAB [11] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                                         OP_JALR, OP_AUIPC, OP_LUI, 5'b11111, 5'b00011};

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_opcode;
  logic [2:0] id_funct3;
  logic       id_funct7_0;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;
  logic       stall, flush, ex_isBranch, ex_Jump, ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic       mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
  logic [1:0] wb_WBSrc, fwd_a, fwd_b;
  logic       ex_illegal;

  ctrl_pipe_unit #(.REG_AW(5), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7_0(id_funct7_0), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_redirect(ex_redirect), .stall(stall), .flush(flush),
    .ex_isBranch(ex_isBranch), .ex_Jump(ex_Jump), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_WBSrc(wb_WBSrc), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic       br, jp, as;
    logic [1:0] ao;
    logic       mr, mw, rw, mt;
    logic [1:0] ws;
    logic       ill;
    logic       dv;
  } ctl_t;

  typedef struct {
    int         due;
    logic [3:0] val;
  } sb_t;

  sb_t mem_q[$];
  sb_t wb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  sb_en    = 1'b0;
  logic [1:0] mon_em;
  logic [3:0] mon_ew;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode table.
  function automatic ctl_t ref_decode(input logic [4:0] op, input logic f7, input logic [2:0] f3);
    ctl_t c;
    c = '0;
    case (op)
      OP_R: begin
        c.ao = 2'b10; c.rw = 1'b1;
        if (MD && f7) begin c.ao = 2'b11; c.dv = f3[2]; end
      end
      OP_I:      begin c.ao = 2'b10; c.as = 1'b1; c.rw = 1'b1; end
      OP_LOAD:   begin c.mr = 1'b1; c.mt = 1'b1; c.as = 1'b1; c.rw = 1'b1; end
      OP_STORE:  begin c.as = 1'b1; c.mw = 1'b1; end
      OP_BRANCH: begin c.br = 1'b1; c.ao = 2'b01; end
      OP_JAL:    begin c.rw = 1'b1; c.jp = 1'b1; c.ws = 2'b11; end
      OP_JALR:   begin c.as = 1'b1; c.rw = 1'b1; c.jp = 1'b1; c.ws = 2'b11; end
      OP_AUIPC:  begin c.rw = 1'b1; c.ws = 2'b10; end
      OP_LUI:    begin c.rw = 1'b1; c.ws = 2'b01; end
      default:   c.ill = 1'b1;
    endcase
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID slot; push=1 means this instruction is accepted this cycle.
  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit push);
    ctl_t c;
    int   d;
    id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7_0 = f7;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    if (push) begin
      c = ref_decode(op, f7, f3);
      d = c.dv ? DIV_LAT - 1 : 0;
      mem_q.push_back('{cyc + 2 + d, {2'b00, c.mr, c.mw}});
      wb_q.push_back('{cyc + 3 + d, {c.rw, c.mt, c.ws}});
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Scoreboard: MEM and WB control must match what was due this cycle, else zero.
  always @(negedge clk) begin
    if (sb_en) begin
      mon_em = 2'b00;
      mon_ew = 4'b0000;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) mon_em = mem_q.pop_front().val[1:0];
      if (wb_q.size() > 0 && wb_q[0].due == cyc) mon_ew = wb_q.pop_front().val;
      checks++;
      if ({mem_MemRead, mem_MemWrite} !== mon_em) begin
        failures++;
        $display("FAIL sb_mem cyc=%0d: got %b expected %b", cyc, {mem_MemRead, mem_MemWrite}, mon_em);
      end
      checks++;
      if ({wb_RegWrite, wb_MemtoReg, wb_WBSrc} !== mon_ew) begin
        failures++;
        $display("FAIL sb_wb cyc=%0d: got %b expected %b", cyc,
                 {wb_RegWrite, wb_MemtoReg, wb_WBSrc}, mon_ew);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; ex_redirect = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({stall, flush, ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
         wb_RegWrite, wb_MemtoReg, wb_WBSrc, fwd_a, fwd_b, ex_illegal} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    tick();
    checks++;
    if ({stall, flush, ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
         wb_RegWrite, wb_MemtoReg, wb_WBSrc, fwd_a, fwd_b, ex_illegal} !== 18'd0) begin
      failures++;
      $display("FAIL reset_idle: got nonzero outputs, expected all 0");
    end
    sb_en = 1'b1;
  endtask

  // Every opcode class in turn, including two illegal ones.
  task automatic test_decode();
    ctl_t c;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, OP_TAB[i], 3'd0, 1'b0, 5'd0, 5'd0, 5'(i + 1), 1'b1);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL decode_stall op=%b: got %b expected 0", OP_TAB[i], stall);
      end
      tick();
      c = ref_decode(OP_TAB[i], 1'b0, 3'd0);
      checks++;
      if ({ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, ex_illegal} !== {c.br, c.jp, c.as, c.ao, c.ill}) begin
        failures++;
        $display("FAIL decode_ex op=%b: got %b expected %b", OP_TAB[i],
                 {ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, ex_illegal}, {c.br, c.jp, c.as, c.ao, c.ill});
      end
    end
    idle();
    repeat (5) tick();
  endtask

  task automatic test_forward();
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 1'b1); tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      failures++; $display("FAIL fwd_exmem: got %b expected 1010", {fwd_a, fwd_b});
    end
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1); tick();
    idle(); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1); tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      failures++; $display("FAIL fwd_memwb: got %b expected 0101", {fwd_a, fwd_b});
    end
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1); tick();
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd7, 5'd0, 5'd8, 1'b1); tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      failures++; $display("FAIL fwd_priority: got %b expected 1000", {fwd_a, fwd_b});
    end
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1); tick();
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1); tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      failures++; $display("FAIL fwd_x0: got %b expected 0000", {fwd_a, fwd_b});
    end
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd13, 1'b1); tick();
    drive(1'b1, OP_STORE, 3'd2, 1'b0, 5'd0, 5'd13, 5'd0, 1'b1); tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0010) begin
      failures++; $display("FAIL fwd_store_rs2: got %b expected 0010", {fwd_a, fwd_b});
    end
    idle();
    repeat (5) tick();
  endtask

  // Load followed by a dependent-or-not instruction; exp_stall says which.
  task automatic lu_case(input string name, input logic [4:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] ld_rd, input bit exp_stall);
    drive(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd0, 5'd0, ld_rd, 1'b1);
    tick();
    drive(1'b1, op, 3'd0, 1'b0, rs1, rs2, 5'd20, !exp_stall);
    #1;
    checks++;
    if (stall !== exp_stall) begin
      failures++; $display("FAIL %s_stall: got %b expected %b", name, stall, exp_stall);
    end
    tick();
    if (exp_stall) begin
      drive(1'b1, op, 3'd0, 1'b0, rs1, rs2, 5'd20, 1'b1);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++; $display("FAIL %s_release: got %b expected 0", name, stall);
      end
      checks++;
      if ({ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp} !== 5'b0) begin
        failures++;
        $display("FAIL %s_bubble: got %b expected 00000", name, {ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp});
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6, 1'b0);
    #1;
    checks++;
    if ({stall, flush} !== 2'b10) begin
      failures++; $display("FAIL lw_add_stall: got %b expected 10", {stall, flush});
    end
    tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    checks++;
    if ({stall, ex_ALUSrc, ex_ALUOp} !== 4'b0000) begin
      failures++; $display("FAIL lw_add_bubble: got %b expected 0000", {stall, ex_ALUSrc, ex_ALUOp});
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      failures++; $display("FAIL lw_add_fwd: got %b expected 0100", {fwd_a, fwd_b});
    end
    idle();
    tick();
    lu_case("lu_store_rs2", OP_STORE, 5'd0, 5'd10, 5'd10, 1'b1);
    lu_case("lu_branch_rs2", OP_BRANCH, 5'd0, 5'd14, 5'd14, 1'b1);
    lu_case("lu_itype_rs2", OP_I, 5'd0, 5'd10, 5'd10, 1'b0);
    lu_case("lu_rd_x0", OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (4) tick();
  endtask

  task automatic test_flush();
    drive(1'b1, OP_BRANCH, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1); tick();
    drive(1'b1, OP_I, 3'd0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b0);
    ex_redirect = 1'b1;
    #1;
    checks++;
    if ({flush, stall, ex_isBranch} !== 3'b101) begin
      failures++; $display("FAIL flush_branch: got %b expected 101", {flush, stall, ex_isBranch});
    end
    tick();
    ex_redirect = 1'b0;
    idle();
    #1;
    checks++;
    if ({flush, ex_ALUSrc, ex_ALUOp} !== 4'b0000) begin
      failures++; $display("FAIL flush_bubble: got %b expected 0000", {flush, ex_ALUSrc, ex_ALUOp});
    end
    tick();
    drive(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6, 1'b0);
    ex_redirect = 1'b1;
    #1;
    checks++;
    if ({flush, stall} !== 2'b10) begin
      failures++; $display("FAIL flush_over_stall: got %b expected 10", {flush, stall});
    end
    tick();
    ex_redirect = 1'b0;
    idle();
    #1;
    checks++;
    if ({stall, ex_ALUOp} !== 3'b000) begin
      failures++; $display("FAIL flush_over_stall_bubble: got %b expected 000", {stall, ex_ALUOp});
    end
    repeat (5) tick();
  endtask

  task automatic test_muldiv();
`ifdef CTRL_MULDIV_EN
    drive(1'b1, OP_R, 3'b100, 1'b1, 5'd0, 5'd0, 5'd12, 1'b1); tick();
    idle();
    for (int k = 1; k <= DIV_LAT; k++) begin
      #1;
      checks++;
      if ({stall, ex_ALUOp} !== {(k < DIV_LAT), 2'b11}) begin
        failures++;
        $display("FAIL div_hold k=%0d: got %b expected %b", k, {stall, ex_ALUOp}, {(k < DIV_LAT), 2'b11});
      end
      tick();
    end
    drive(1'b1, OP_R, 3'b000, 1'b1, 5'd0, 5'd0, 5'd13, 1'b1); tick();
    idle();
    #1;
    checks++;
    if ({stall, ex_ALUOp} !== 3'b011) begin
      failures++; $display("FAIL mul_nostall: got %b expected 011", {stall, ex_ALUOp});
    end
`else
    drive(1'b1, OP_R, 3'b100, 1'b1, 5'd0, 5'd0, 5'd12, 1'b1); tick();
    idle();
    #1;
    checks++;
    if ({stall, ex_ALUOp} !== 3'b010) begin
      failures++; $display("FAIL div_as_plain_r: got %b expected 010", {stall, ex_ALUOp});
    end
`endif
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    int idx;
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(0, 10);
      drive(1'b1, OP_TAB[idx], 3'd0, 1'b0, 5'd0, 5'd0, 5'($urandom_range(1, 31)), 1'b1);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++; $display("FAIL b2b_stall i=%0d: got %b expected 0", i, stall);
      end
      tick();
    end
    idle();
    repeat (5) tick();
    checks++;
    if (mem_q.size() + wb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", mem_q.size() + wb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    sb_en = 1'b0;
    mem_q.delete();
    wb_q.delete();
    drive(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0); tick();
    drive(1'b1, OP_R, 3'd0, 1'b0, 5'd5, 5'd0, 5'd6, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: got %b expected 1", stall);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({stall, flush, ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
         wb_RegWrite, wb_MemtoReg, wb_WBSrc, fwd_a, fwd_b, ex_illegal} !== 18'd0) begin
      failures++; $display("FAIL rst_mid_stall: got nonzero outputs expected all 0");
    end
    idle();
`ifdef CTRL_MULDIV_EN
    drive(1'b1, OP_R, 3'b101, 1'b1, 5'd0, 5'd0, 5'd12, 1'b0); tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({stall, ex_ALUOp} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_div: got %b expected 000", {stall, ex_ALUOp});
    end
`endif
    tick();
    checks++;
    if ({stall, flush, ex_isBranch, ex_Jump, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
         wb_RegWrite, wb_MemtoReg, wb_WBSrc, fwd_a, fwd_b, ex_illegal} !== 18'd0) begin
      failures++; $display("FAIL rst_mid_after: got nonzero outputs expected all 0");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_redirect = 1'b0;
    idle();
    test_reset();
    test_decode();
    test_forward();
    test_load_use();
    test_flush();
    test_muldiv();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
